// File: rtl/lsu_mem_master.sv
// lsu_mem_master
// Load/store unit bridge between a core request/response handshake and a
// single-port, combinational-read, synchronous-write word memory.
// Sub-word stores are done as read-modify-write; loads are lane-selected
// and sign/zero-extended. Misaligned, illegal-size and out-of-range
// requests get an immediate error response and never touch memory.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   req_valid/req_ready core request handshake (ready only in IDLE)
//   req_we              1 = store, 0 = load
//   req_size            00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned        loads: 1 = zero-extend, 0 = sign-extend
//   req_addr            byte address
//   req_wdata           right-aligned store data
//   resp_valid/ready    response handshake
//   resp_rdata          extended load data (0 for stores and errors)
//   resp_err            request rejected
//   mem_A, mem_WD       word-aligned memory address / write data
//   mem_WE              memory write enable (one cycle, WRITE state only)
//   mem_RD              combinational read data for mem_A
module lsu_mem_master #(
    parameter int MEM_WORDS = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_A,
    output logic [31:0] mem_WD,
    output logic        mem_WE,
    input  logic [31:0] mem_RD
);

    localparam logic [31:0] MEM_WORDS_W = 32'(MEM_WORDS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t      state_r;
    state_t      state_nxt_s;
    logic        phase_r;      // second READ cycle of a load
    logic        we_r;
    logic [1:0]  size_r;
    logic        uns_r;
    logic [31:0] addr_r;
    logic [31:0] wdata_r;
    logic [31:0] word_r;       // word captured from memory in READ
    logic [31:0] rdata_r;
    logic        err_r;
    logic        req_err_s;
    logic        accept_s;

    // Lane select and extension of a captured word for a load.
    function automatic logic [31:0] load_extend(input logic [31:0] word,
                                                input logic [1:0]  size,
                                                input logic [1:0]  off,
                                                input logic        uns);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (off)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            2'd3:    b = word[31:24];
            default: b = 8'd0;
        endcase
        h = off[1] ? word[31:16] : word[15:0];
        case (size)
            2'b00:   r = uns ? {24'd0, b} : {{24{b[7]}}, b};
            2'b01:   r = uns ? {16'd0, h} : {{16{h[15]}}, h};
            2'b10:   r = word;
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    // Builds the word to be written: full word, or old word with one lane replaced.
    function automatic logic [31:0] store_merge(input logic [31:0] word,
                                                input logic [31:0] wdata,
                                                input logic [1:0]  size,
                                                input logic [1:0]  off);
        logic [31:0] r;
        r = word;
        case (size)
            2'b00: begin
                case (off)
                    2'd0:    r[7:0]   = wdata[7:0];
                    2'd1:    r[15:8]  = wdata[7:0];
                    2'd2:    r[23:16] = wdata[7:0];
                    2'd3:    r[31:24] = wdata[7:0];
                    default: r = word;
                endcase
            end
            2'b01: begin
                if (off[1]) begin
                    r[31:16] = wdata[15:0];
                end else begin
                    r[15:0] = wdata[15:0];
                end
            end
            2'b10:   r = wdata;
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    // Request legality check on the live request fields.
    always_comb begin
        req_err_s = 1'b0;
        case (req_size)
            2'b00:   req_err_s = 1'b0;
            2'b01:   req_err_s = req_addr[0];
            2'b10:   req_err_s = (req_addr[1:0] != 2'b00);
            default: req_err_s = 1'b1;
        endcase
        if ({2'b00, req_addr[31:2]} >= MEM_WORDS_W) begin
            req_err_s = 1'b1;
        end else begin
            req_err_s = req_err_s;
        end
    end

    assign accept_s = req_valid && (state_r == IDLE);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (!accept_s) begin
                    state_nxt_s = IDLE;
                end else if (req_err_s) begin
                    state_nxt_s = RESP;
                end else if (req_we && (req_size == 2'b10)) begin
                    state_nxt_s = WRITE;
                end else begin
                    state_nxt_s = READ;
                end
            end
            READ: begin
                // Loads spend a second READ cycle forming the extended result.
                if (we_r) begin
                    state_nxt_s = WRITE;
                end else if (phase_r) begin
                    state_nxt_s = RESP;
                end else begin
                    state_nxt_s = READ;
                end
            end
            WRITE:   state_nxt_s = RESP;
            RESP: begin
                if (resp_ready) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = RESP;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Request capture, memory word capture and response registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_r <= 1'b0;
            we_r    <= 1'b0;
            size_r  <= 2'b00;
            uns_r   <= 1'b0;
            addr_r  <= 32'd0;
            wdata_r <= 32'd0;
            word_r  <= 32'd0;
            rdata_r <= 32'd0;
            err_r   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        we_r    <= req_we;
                        size_r  <= req_size;
                        uns_r   <= req_unsigned;
                        addr_r  <= req_addr;
                        wdata_r <= req_wdata;
                        err_r   <= req_err_s;
                        rdata_r <= 32'd0;
                        phase_r <= 1'b0;
                    end
                end
                READ: begin
                    if (!phase_r) begin
                        word_r  <= mem_RD;
                        phase_r <= 1'b1;
                    end else begin
                        rdata_r <= load_extend(word_r, size_r, addr_r[1:0], uns_r);
                        phase_r <= 1'b0;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        rdata_r <= 32'd0;
                        err_r   <= 1'b0;
                    end
                end
                default: begin
                    phase_r <= phase_r;
                end
            endcase
        end
    end

    // Output decode from registered state.
    always_comb begin
        req_ready  = (state_r == IDLE);
        resp_valid = (state_r == RESP);
        resp_rdata = rdata_r;
        resp_err   = err_r;
        mem_A      = 32'd0;
        mem_WD     = 32'd0;
        mem_WE     = 1'b0;
        case (state_r)
            READ: begin
                mem_A = {addr_r[31:2], 2'b00};
            end
            WRITE: begin
                mem_A  = {addr_r[31:2], 2'b00};
                mem_WD = store_merge(word_r, wdata_r, size_r, addr_r[1:0]);
                mem_WE = 1'b1;
            end
            default: begin
                mem_A = 32'd0;
            end
        endcase
    end

endmodule
